bullet_slot_manager: RTL and testbench

- Owns the MAX_BULLETS-entry bullet table that the VGA renderer draws; drives the packed allBulletContents bus directly.
- Arbitrates fire requests from both tanks (round-robin), allocates the lowest free slot, enforces per-player cooldown, and advances and retires bullets once per frame.
- Sits between the joystick/CPU fire logic and VGAController; advancement is paced by screenEnd, so position updates happen during blanking.

---
 rtl/bullet_slot_manager.sv | 201 ++++++++++++++++++++
 tb/tb_bullet_slot_manager.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_slot_manager.sv
// Bullet table owner: arbitrates fire requests from two tanks, allocates the
// lowest free slot, enforces per-player cooldown and advances/retires bullets
// once per frame. The packed slot table is driven straight to the renderer.
module bullet_slot_manager #(
    parameter int unsigned MAX_BULLETS     = 64,
    parameter int unsigned SPEED           = 4,
    parameter int unsigned BULLET_SIZE     = 12,
    parameter int unsigned SPRITE_SIZE     = 64,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned VIDEO_WIDTH     = 640,
    parameter int unsigned VIDEO_HEIGHT    = 480
) (
    input  logic                          clk,
    input  logic                          CPU_RESETN,
    input  logic                          frame_tick,
    input  logic                          p1_fire_req,
    input  logic                          p2_fire_req,
    input  logic [9:0]                    p1_x,
    input  logic [9:0]                    p2_x,
    input  logic [8:0]                    p1_y,
    input  logic [8:0]                    p2_y,
    input  logic [1:0]                    p1_dir,
    input  logic [1:0]                    p2_dir,
    output logic                          p1_fire_ack,
    output logic                          p2_fire_ack,
    output logic                          p1_fire_drop,
    output logic                          p2_fire_drop,
    output logic [32*MAX_BULLETS-1:0]     allBulletContents,
    output logic [$clog2(MAX_BULLETS):0]  active_count,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned IW  = $clog2(MAX_BULLETS);
    localparam int unsigned CW  = IW + 1;
    localparam int unsigned CDW = $clog2(COOLDOWN_FRAMES + 1);
    localparam int unsigned OFS = (SPRITE_SIZE - BULLET_SIZE) / 2;

    localparam logic signed [11:0] SPD_S = 12'(SPEED);
    localparam logic signed [11:0] BS_S  = 12'(BULLET_SIZE);
    localparam logic signed [11:0] W_S   = 12'(VIDEO_WIDTH);
    localparam logic signed [11:0] H_S   = 12'(VIDEO_HEIGHT);

    typedef enum logic [1:0] {IDLE, ALLOC, SWEEP} state_t;

    state_t           state, state_next;
    logic [31:0]      slot [MAX_BULLETS];
    logic             grant;        // player being serviced in ALLOC (0 = p1)
    logic             last_grant;
    logic [CDW-1:0]   cd1, cd2;
    logic [IW-1:0]    sweep_idx;

    logic             elig1, elig2, grant_sel, load_grant, sweep_last;
    logic             free_found;
    logic [IW-1:0]    free_idx;
    logic [9:0]       req_x;
    logic [8:0]       req_y;
    logic [1:0]       req_dir;
    logic [10:0]      spawn_x, spawn_y;
    logic             on_screen, alloc_ok, alloc_fail;
    logic [31:0]      spawn_word, cur, moved_word;
    logic signed [11:0] nx, ny;
    logic             off_screen, sweep_wr, sweep_clear;

    // Slot table is exposed as a flat bus, slot j at [32j+31:32j]
    for (genvar g = 0; g < int'(MAX_BULLETS); g++) begin : g_bus
        assign allBulletContents[32*g +: 32] = slot[g];
    end

    // Request eligibility and round-robin tie break
    always_comb begin
        elig1     = p1_fire_req && (cd1 == '0);
        elig2     = p2_fire_req && (cd2 == '0);
        grant_sel = (elig1 && elig2) ? ~last_grant : elig2;
        sweep_last = (sweep_idx == IW'(MAX_BULLETS - 1));
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_next = SWEEP;
                end else if (elig1 || elig2) begin
                    state_next = ALLOC;
                    load_grant = 1'b1;
                end
            end
            ALLOC:   state_next = frame_tick ? SWEEP : IDLE;
            SWEEP:   if (sweep_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= IDLE;
        else             state <= state_next;
    end

    // Lowest inactive slot
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int j = int'(MAX_BULLETS) - 1; j >= 0; j--) begin
            if (!slot[j][3]) begin
                free_found = 1'b1;
                free_idx   = IW'(j);
            end
        end
    end

    // Spawn word for the granted player, centred on its sprite
    always_comb begin
        req_x      = grant ? p2_x   : p1_x;
        req_y      = grant ? p2_y   : p1_y;
        req_dir    = grant ? p2_dir : p1_dir;
        spawn_x    = 11'(req_x) + 11'(OFS);
        spawn_y    = 11'(req_y) + 11'(OFS);
        on_screen  = (spawn_x + 11'(BULLET_SIZE) <= 11'(VIDEO_WIDTH)) &&
                     (spawn_y + 11'(BULLET_SIZE) <= 11'(VIDEO_HEIGHT));
        alloc_ok   = (state == ALLOC) && free_found && on_screen;
        alloc_fail = (state == ALLOC) && !alloc_ok;
        spawn_word = {spawn_x[9:0], spawn_y[8:0], req_dir, grant, 6'd0, 1'b1, 3'd0};
    end

    // Advance the slot under the sweep index; clear it if it leaves the screen
    always_comb begin
        cur = slot[sweep_idx];
        nx  = $signed({2'b00, cur[31:22]});
        ny  = $signed({3'b000, cur[21:13]});
        unique case (cur[12:11])
            2'd0:    ny = ny - SPD_S;
            2'd1:    nx = nx + SPD_S;
            2'd2:    ny = ny + SPD_S;
            default: nx = nx - SPD_S;
        endcase
        off_screen  = nx[11] || ny[11] || (nx + BS_S > W_S) || (ny + BS_S > H_S);
        moved_word  = off_screen ? 32'd0 : {nx[9:0], ny[8:0], cur[12:0]};
        sweep_wr    = (state == SWEEP) && cur[3];
        sweep_clear = sweep_wr && off_screen;
    end

    // Slot table writes: allocation or sweep update
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < int'(MAX_BULLETS); i++) slot[i] <= '0;
        end else if (alloc_ok) begin
            slot[free_idx] <= spawn_word;
        end else if (sweep_wr) begin
            slot[sweep_idx] <= moved_word;
        end
    end

    // Arbitration, cooldown, occupancy and status registers
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            cd1          <= '0;
            cd2          <= '0;
            sweep_idx    <= '0;
            active_count <= '0;
            p1_fire_ack  <= 1'b0;
            p2_fire_ack  <= 1'b0;
            p1_fire_drop <= 1'b0;
            p2_fire_drop <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load_grant) grant <= grant_sel;
            if (alloc_ok)   last_grant <= grant;

            if (alloc_ok && !grant) begin
                cd1 <= CDW'(COOLDOWN_FRAMES);
            end else if (state == SWEEP && sweep_last && cd1 != '0) begin
                cd1 <= cd1 - CDW'(1);
            end
            if (alloc_ok && grant) begin
                cd2 <= CDW'(COOLDOWN_FRAMES);
            end else if (state == SWEEP && sweep_last && cd2 != '0) begin
                cd2 <= cd2 - CDW'(1);
            end

            sweep_idx <= (state == SWEEP && !sweep_last) ? sweep_idx + IW'(1) : '0;

            if (alloc_ok)         active_count <= active_count + CW'(1);
            else if (sweep_clear) active_count <= active_count - CW'(1);

            p1_fire_ack  <= alloc_ok && !grant;
            p2_fire_ack  <= alloc_ok && grant;
            p1_fire_drop <= alloc_fail && !grant;
            p2_fire_drop <= alloc_fail && grant;
            busy         <= (state_next == SWEEP);
            overrun      <= overrun || (state == SWEEP && frame_tick);
        end
    end

endmodule

// File: tb/tb_bullet_slot_manager.sv
// Directed bench for bullet_slot_manager. A default-parameter instance covers
// arbitration, cooldown, movement and reset; a second instance with a one-frame
// cooldown is used to fill the whole table. Both share the stimulus.
module tb_bullet_slot_manager;

    localparam int unsigned NB = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       CPU_RESETN, frame_tick, p1_fire_req, p2_fire_req;
    logic [9:0] p1_x, p2_x;
    logic [8:0] p1_y, p2_y;
    logic [1:0] p1_dir, p2_dir;

    logic              m_a1, m_a2, m_d1, m_d2, m_busy, m_ovr;
    logic [32*NB-1:0]  m_bus;
    logic [6:0]        m_cnt;
    logic              f_a1, f_a2, f_d1, f_d2, f_busy, f_ovr;
    logic [32*NB-1:0]  f_bus;
    logic [6:0]        f_cnt;

    logic              sel;
    logic              a1, a2, d1, d2, busy, ovr;
    logic [32*NB-1:0]  bus, snap;
    logic [6:0]        cnt;

    assign a1   = sel ? f_a1   : m_a1;
    assign a2   = sel ? f_a2   : m_a2;
    assign d1   = sel ? f_d1   : m_d1;
    assign d2   = sel ? f_d2   : m_d2;
    assign busy = sel ? f_busy : m_busy;
    assign ovr  = sel ? f_ovr  : m_ovr;
    assign bus  = sel ? f_bus  : m_bus;
    assign cnt  = sel ? f_cnt  : m_cnt;

    bullet_slot_manager dut (
        .clk(clk), .CPU_RESETN(CPU_RESETN), .frame_tick(frame_tick),
        .p1_fire_req(p1_fire_req), .p2_fire_req(p2_fire_req),
        .p1_x(p1_x), .p2_x(p2_x), .p1_y(p1_y), .p2_y(p2_y),
        .p1_dir(p1_dir), .p2_dir(p2_dir),
        .p1_fire_ack(m_a1), .p2_fire_ack(m_a2),
        .p1_fire_drop(m_d1), .p2_fire_drop(m_d2),
        .allBulletContents(m_bus), .active_count(m_cnt),
        .busy(m_busy), .overrun(m_ovr)
    );

    bullet_slot_manager #(.COOLDOWN_FRAMES(1)) dut_fast (
        .clk(clk), .CPU_RESETN(CPU_RESETN), .frame_tick(frame_tick),
        .p1_fire_req(p1_fire_req), .p2_fire_req(p2_fire_req),
        .p1_x(p1_x), .p2_x(p2_x), .p1_y(p1_y), .p2_y(p2_y),
        .p1_dir(p1_dir), .p2_dir(p2_dir),
        .p1_fire_ack(f_a1), .p2_fire_ack(f_a2),
        .p1_fire_drop(f_d1), .p2_fire_drop(f_d2),
        .allBulletContents(f_bus), .active_count(f_cnt),
        .busy(f_busy), .overrun(f_ovr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a1n, a2n, d1n, d2n, a1_at, a2_at, ev_at;
    int n, lat, t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int x, input int y, input int d, input int o);
        return {10'(x), 9'(y), 2'(d), 1'(o), 6'd0, 1'b1, 3'd0};
    endfunction

    function automatic logic [31:0] slot_of(input int j);
        return bus[32*j +: 32];
    endfunction

    // One clock; record ack/drop pulses and release the matching request
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (a1) begin a1n++; a1_at = cyc; ev_at = cyc; p1_fire_req = 1'b0; end
        if (a2) begin a2n++; a2_at = cyc; ev_at = cyc; p2_fire_req = 1'b0; end
        if (d1) begin d1n++; ev_at = cyc; p1_fire_req = 1'b0; end
        if (d2) begin d2n++; ev_at = cyc; p2_fire_req = 1'b0; end
    endtask

    task automatic do_reset();
        CPU_RESETN  = 1'b0;
        frame_tick  = 1'b0;
        p1_fire_req = 1'b0;
        p2_fire_req = 1'b0;
        step();
        step();
        CPU_RESETN = 1'b1;
        step();
        a1n = 0; a2n = 0; d1n = 0; d2n = 0;
    endtask

    task automatic set_p(input int p, input int x, input int y, input int d);
        if (p == 1) begin p1_x = 10'(x); p1_y = 9'(y); p1_dir = 2'(d); end
        else        begin p2_x = 10'(x); p2_y = 9'(y); p2_dir = 2'(d); end
    endtask

    // Single request; lat = cycles from request to ack/drop
    task automatic fire(input int p, output int l);
        int s;
        s = cyc;
        if (p == 1) p1_fire_req = 1'b1;
        else        p2_fire_req = 1'b1;
        for (int i = 0; i < 12 && (p == 1 ? p1_fire_req : p2_fire_req); i++) step();
        if (p == 1 ? p1_fire_req : p2_fire_req) begin
            check("fire_timeout", 32'd1, 32'd0);
            p1_fire_req = 1'b0;
            p2_fire_req = 1'b0;
        end
        l = ev_at - s;
    endtask

    task automatic wait_both();
        for (int i = 0; i < 12 && (p1_fire_req || p2_fire_req); i++) step();
        if (p1_fire_req || p2_fire_req) begin
            check("pair_timeout", 32'd1, 32'd0);
            p1_fire_req = 1'b0;
            p2_fire_req = 1'b0;
        end
    endtask

    // One frame tick; k = number of sampled cycles with busy high
    task automatic frame(output int k);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            k++;
            step();
        end
        if (k >= 200) check("sweep_timeout", 32'(k), 32'd64);
    endtask

    initial begin
        sel = 1'b0;
        set_p(1, 0, 0, 0);
        set_p(2, 0, 0, 0);
        do_reset();

        // Reset state
        check("rst_cnt",  32'(cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr",  32'(ovr), 32'd0);
        check("rst_bus",  32'(|bus), 32'd0);
        check("rst_pulses", 32'({a1, a2, d1, d2}), 32'd0);

        // Basic fire
        set_p(1, 100, 200, 1);
        fire(1, lat);
        check("fire_lat", 32'(lat), 32'd2);
        check("fire_slot0", slot_of(0), mk(126, 226, 1, 0));
        check("fire_cnt", 32'(cnt), 32'd1);

        // Cooldown: held request waits for 8 completed sweeps
        set_p(1, 100, 200, 2);
        p1_fire_req = 1'b1;
        for (int k = 0; k < 7; k++) frame(n);
        check("cd_hold", 32'(a1n), 32'd1);
        frame(n);
        t0 = cyc;
        for (int i = 0; i < 6 && p1_fire_req; i++) step();
        check("cd_release", 32'(a1n), 32'd2);
        check("cd_lat", 32'(a1_at - t0), 32'd2);
        check("cd_slot0", slot_of(0), mk(158, 226, 1, 0));
        check("cd_slot1", slot_of(1), mk(126, 226, 2, 0));

        // Round robin: p1 granted last, so p2 wins the tie
        for (int k = 0; k < 8; k++) frame(n);
        set_p(1, 100, 200, 3);
        set_p(2, 300, 100, 0);
        t0 = cyc;
        p1_fire_req = 1'b1;
        p2_fire_req = 1'b1;
        wait_both();
        check("rr_p2_first", 32'(a2_at - t0), 32'd2);
        check("rr_p1_second", 32'(a1_at - t0), 32'd4);
        check("rr_slot0", slot_of(0), mk(190, 226, 1, 0));
        check("rr_slot1", slot_of(1), mk(126, 258, 2, 0));
        check("rr_slot2", slot_of(2), mk(326, 126, 0, 1));
        check("rr_slot3", slot_of(3), mk(126, 226, 3, 0));
        check("rr_cnt", 32'(cnt), 32'd4);

        // Right-edge retirement and off-screen spawn drops
        do_reset();
        set_p(1, 594, 200, 1);
        fire(1, lat);
        check("edge_spawn", slot_of(0), mk(620, 226, 1, 0));
        frame(n);
        check("busy_len", 32'(n), 32'd64);
        check("edge_f1", slot_of(0), mk(624, 226, 1, 0));
        frame(n);
        check("edge_f2", slot_of(0), mk(628, 226, 1, 0));
        check("edge_f2_cnt", 32'(cnt), 32'd1);
        frame(n);
        check("edge_f3", slot_of(0), 32'd0);
        check("edge_f3_cnt", 32'(cnt), 32'd0);
        set_p(2, 610, 200, 0);
        fire(2, lat);
        check("drop_x", 32'(d2n), 32'd1);
        set_p(2, 100, 460, 0);
        fire(2, lat);
        check("drop_y", 32'(d2n), 32'd2);
        check("drop_noack", 32'(a2n), 32'd0);
        check("drop_cnt", 32'(cnt), 32'd0);
        set_p(2, 100, 442, 0);
        fire(2, lat);
        check("ybound_ack", 32'(a2n), 32'd1);
        check("ybound_slot0", slot_of(0), mk(126, 468, 0, 1));

        // Overrun: second tick inside a sweep
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int i = 0; i < 5; i++) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("ovr_set", 32'(ovr), 32'd1);
        for (int i = 0; i < 100 && busy; i++) step();
        frame(n);
        check("ovr_sticky", 32'(ovr), 32'd1);
        check("ovr_len", 32'(n), 32'd64);

        // Reset in the middle of a sweep
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mr_busy_before", 32'(busy), 32'd1);
        CPU_RESETN = 1'b0;
        #1;
        check("mr_bus", 32'(|bus), 32'd0);
        check("mr_cnt", 32'(cnt), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_ovr", 32'(ovr), 32'd0);
        step();
        CPU_RESETN = 1'b1;
        step();
        set_p(1, 100, 200, 1);
        fire(1, lat);
        check("mr_fire_lat", 32'(lat), 32'd2);
        check("mr_slot0", slot_of(0), mk(126, 226, 1, 0));

        // Fill the table on the fast-cooldown instance
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            if (i == 0) set_p(1, 474, 200, 1);
            else        set_p(1, 100, 440, 0);
            set_p(2, 300, 440, 0);
            p1_fire_req = 1'b1;
            p2_fire_req = 1'b1;
            wait_both();
            frame(n);
        end
        check("fill_cnt", 32'(cnt), 32'd64);
        check("fill_a1", 32'(a1n), 32'd32);
        check("fill_a2", 32'(a2n), 32'd32);
        check("fill_slot0", slot_of(0), mk(628, 226, 1, 0));
        check("fill_slot1", slot_of(1), mk(326, 338, 0, 1));
        check("fill_slot63", slot_of(63), mk(326, 462, 0, 1));
        snap = bus;
        set_p(1, 100, 440, 0);
        fire(1, lat);
        check("full_drop", 32'(d1n), 32'd1);
        check("full_noack", 32'(a1n), 32'd32);
        check("full_bus_same", 32'(bus == snap), 32'd1);
        check("full_cnt", 32'(cnt), 32'd64);
        frame(n);
        check("retire_slot0", slot_of(0), 32'd0);
        check("retire_cnt", 32'(cnt), 32'd63);
        fire(1, lat);
        check("reuse_lat", 32'(lat), 32'd2);
        check("reuse_slot0", slot_of(0), mk(126, 466, 0, 0));
        check("reuse_cnt", 32'(cnt), 32'd64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
